// File: rtl/mdio_pkg.sv
// Shared types for the MDIO arbiter: FSM states, clause-22 opcodes and the frame layout.
package mdio_pkg;

  localparam int FRAME_W = 32;

  localparam logic [1:0] ST_CL22  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_GAP
  } arb_state_t;

  // Field order gives the bit positions: st [31:30] ... data [15:0].
  typedef struct packed {
    logic [1:0]  st;
    logic [1:0]  op;
    logic [4:0]  phy;
    logic [4:0]  reg_addr;
    logic [1:0]  ta;
    logic [15:0] data;
  } mdio_frame_t;

  function automatic logic frame_bad(input mdio_frame_t f);
    return (f.st != ST_CL22) || !((f.op == OP_WRITE) || (f.op == OP_READ));
  endfunction

endpackage

// File: rtl/mdio_rr_pick.sv
// Round-robin picker: first valid requester at or after rr_ptr, wrapping.
// Purely combinational; a requester is never granted unless its valid is set.
module mdio_rr_pick
  import mdio_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IW-1:0]   rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            any_valid
);

  // Scan offsets from farthest to nearest so the nearest valid one wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_valid = |req_valid;
    for (int i = NREQ - 1; i >= 0; i--) begin
      int k;
      k = int'(rr_ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      if (req_valid[k]) begin
        grant     = '0;
        grant[k]  = 1'b1;
        grant_idx = IW'(k);
      end
    end
  end

endmodule

// File: rtl/mdio_arbiter.sv
// Round-robin share of one MDIO frame generator; req_ready->mdio_start 1 cycle, ->rsp_valid FRAME_CYCLES+2.
// One frame in flight, others wait with no pre-emption; MDIO_ARB_OPCHECK_EN rejects non-CL22/bad-OP frames.
module mdio_arbiter
  import mdio_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int FRAME_CYCLES = 68,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [FRAME_W*NREQ-1:0] req_frame,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [15:0]             rsp_data,
  output logic                    rsp_err,
  output logic                    mdio_start,
  output logic [FRAME_W-1:0]      t_data,
  input  logic                    gen_data_rdy,
  input  logic [15:0]             gen_rd_data
);

  localparam int IW      = $clog2(NREQ);
  localparam int CNT_MAX = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  arb_state_t  state_q, state_d;
  logic [IW-1:0] rr_ptr_q;
  logic [IW-1:0] gnt_idx_q;
  mdio_frame_t frame_q;
  logic [CW-1:0] cnt_q;
  logic        got_rd_q;
  logic [15:0] rd_data_q;
  logic        bad_q;

  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  mdio_frame_t     sel_frame;
  logic            grant_fire;
  logic            bad_d;
  logic            rd_capture;

  mdio_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (pick_gnt),
    .grant_idx (pick_idx),
    .any_valid (pick_any)
  );

  assign sel_frame = mdio_frame_t'(req_frame[int'(pick_idx)*FRAME_W +: FRAME_W]);

  always_comb begin
    state_d    = state_q;
    grant_fire = 1'b0;
    bad_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          grant_fire = 1'b1;
`ifdef MDIO_ARB_OPCHECK_EN
          bad_d   = frame_bad(sel_frame);
          state_d = bad_d ? S_RESP : S_ISSUE;
`else
          state_d = S_ISSUE;
`endif
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (cnt_q == FRAME_LAST) state_d = S_RESP;
      S_RESP:  state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      S_GAP:   if (cnt_q == GAP_LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Only the first strobe of a read counts, including one on the final WAIT cycle.
  assign rd_capture = (state_q == S_WAIT) && (frame_q.op == OP_READ) && !got_rd_q && gen_data_rdy;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      gnt_idx_q <= '0;
      frame_q   <= '0;
      cnt_q     <= '0;
      got_rd_q  <= 1'b0;
      rd_data_q <= '0;
      bad_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_fire) begin
        frame_q   <= sel_frame;
        gnt_idx_q <= pick_idx;
        rr_ptr_q  <= (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + IW'(1);
        got_rd_q  <= 1'b0;
        rd_data_q <= '0;
        bad_q     <= bad_d;
      end
      if ((state_q == S_WAIT) || (state_q == S_GAP)) cnt_q <= cnt_q + CW'(1);
      else cnt_q <= '0;
      if (rd_capture) begin
        got_rd_q  <= 1'b1;
        rd_data_q <= gen_rd_data;
      end
    end
  end

  // req_ready is combinational, so it is masked while reset is held.
  assign req_ready  = (reset && (state_q == S_IDLE)) ? pick_gnt : '0;
  assign mdio_start = (state_q == S_ISSUE);
  assign t_data     = ((state_q == S_ISSUE) || (state_q == S_WAIT)) ? frame_q : '0;
  assign rsp_valid  = (state_q == S_RESP) ? (NREQ'(1) << gnt_idx_q) : '0;
  assign rsp_data   = (state_q == S_RESP) ? rd_data_q : 16'h0;
  assign rsp_err    = (state_q == S_RESP) && (bad_q || ((frame_q.op == OP_READ) && !got_rd_q));

endmodule

// File: tb/tb_mdio_arbiter.sv
// Scoreboard bench for mdio_arbiter: expected responses queued at request time, checked as they complete.
module tb_mdio_arbiter;

  localparam int NREQ         = 4;
  localparam int FRAME_CYCLES = 68;
  localparam int GAP_CYCLES   = 2;
  localparam int RSP_LAT      = FRAME_CYCLES + 2;
  localparam int NONE         = 999;

  logic                 clk;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [32*NREQ-1:0]   req_frame;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      rsp_valid;
  logic [15:0]          rsp_data;
  logic                 rsp_err;
  logic                 mdio_start;
  logic [31:0]          t_data;
  logic                 gen_data_rdy;
  logic [15:0]          gen_rd_data;

  mdio_arbiter #(
    .NREQ         (NREQ),
    .FRAME_CYCLES (FRAME_CYCLES),
    .GAP_CYCLES   (GAP_CYCLES)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_frame    (req_frame),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .mdio_start   (mdio_start),
    .t_data       (t_data),
    .gen_data_rdy (gen_data_rdy),
    .gen_rd_data  (gen_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [15:0] data;
    logic        err;
    int          lat;
    int          ord;
  } exp_t;

  typedef struct {
    int              cyc;
    logic [NREQ-1:0] vld;
    logic [15:0]     data;
    logic            err;
  } obs_t;

  exp_t exp_q[$];
  obs_t obs_q[$];
  int   rdy_cyc_q[$];
  int   rdy_idx_q[$];

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          rsp_cnt = 0;
  int          start_cnt = 0;
  int          start_cyc = 0;
  logic [31:0] start_tdata = '0;
  int          mon_idx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (|req_ready) begin
      mon_idx = 0;
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) mon_idx = i;
      rdy_cyc_q.push_back(cyc);
      rdy_idx_q.push_back(mon_idx);
    end
    if (mdio_start) begin
      start_cnt   = start_cnt + 1;
      start_cyc   = cyc;
      start_tdata = t_data;
    end
    if (|rsp_valid) begin
      obs_q.push_back('{cyc, rsp_valid, rsp_data, rsp_err});
      rsp_cnt = rsp_cnt + 1;
    end
  end

  task automatic push_exp(input int idx, input logic [15:0] d, input logic e, input int lat, input int ord);
    exp_q.push_back('{idx, d, e, lat, ord});
  endtask

  task automatic compare_rsp();
    exp_t e;
    obs_t o;
    if (exp_q.size() == 0 || obs_q.size() == 0) begin
      chk("rsp_avail", 32'(obs_q.size()), 32'(exp_q.size()));
      return;
    end
    e = exp_q.pop_front();
    o = obs_q.pop_front();
    chk("rsp_valid", 32'(o.vld), 32'(1 << e.idx));
    chk("rsp_data", 32'(o.data), 32'(e.data));
    chk("rsp_err", 32'(o.err), 32'(e.err));
    if (e.ord < rdy_cyc_q.size()) chk("rsp_lat", 32'(o.cyc - rdy_cyc_q[e.ord]), 32'(e.lat));
    else chk("rsp_grant_log", 32'(rdy_cyc_q.size()), 32'(e.ord + 1));
  endtask

  // k1/k2: WAIT cycle index at which to strobe the generator (WAIT cycle k is k+2 after grant).
  task automatic run_frame(input int idx, input logic [31:0] frame,
                           input int k1, input logic [15:0] d1,
                           input int k2, input logic [15:0] d2,
                           input logic [15:0] exp_d, input logic exp_e,
                           input int lat, input bit exp_start);
    int r0, s0, ord;
    bit seen;
    ord = rdy_cyc_q.size();
    push_exp(idx, exp_d, exp_e, lat, ord);
    r0 = rsp_cnt;
    s0 = start_cnt;
    req_frame[32*idx +: 32] = frame;
    req_valid[idx] = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 300 && !seen; t++) begin
      @(negedge clk);
      if (req_ready[idx]) seen = 1'b1;
    end
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
    if (!seen) begin
      chk("ready_timeout", 32'(0), 32'(1));
      void'(exp_q.pop_back());
      return;
    end
    for (int t = 1; t < 300 && rsp_cnt == r0; t++) begin
      gen_data_rdy = (t == k1 + 2) || (t == k2 + 2);
      gen_rd_data  = (t == k2 + 2) ? d2 : d1;
      @(posedge clk); #1;
    end
    gen_data_rdy = 1'b0;
    gen_rd_data  = '0;
    chk("rsp_count", 32'(rsp_cnt - r0), 32'(1));
    compare_rsp();
    if (exp_start) begin
      chk("start_count", 32'(start_cnt - s0), 32'(1));
      chk("start_lat", 32'(start_cyc - rdy_cyc_q[ord]), 32'(1));
      chk("start_tdata", start_tdata, frame);
    end else begin
      chk("no_start", 32'(start_cnt - s0), 32'(0));
    end
    repeat (GAP_CYCLES + 1) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int r0, b0;
    bit seen;
    reset        = 1'b0;
    req_valid    = '0;
    req_frame    = '0;
    gen_data_rdy = 1'b0;
    gen_rd_data  = '0;

    // Reset with all requesters pending: nothing may leak out.
    for (int i = 0; i < NREQ; i++) req_frame[32*i +: 32] = 32'h5AB80000 + 32'(i);
    req_valid = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp_data", 32'(rsp_data), 32'(0));
    chk("rst_rsp_err", 32'(rsp_err), 32'(0));
    chk("rst_mdio_start", 32'(mdio_start), 32'(0));
    chk("rst_t_data", t_data, 32'(0));

    // Round-robin with every requester held valid from reset.
    b0 = rdy_cyc_q.size();
    push_exp(0, 16'h0, 1'b0, RSP_LAT, b0 + 0);
    push_exp(1, 16'h0, 1'b0, RSP_LAT, b0 + 1);
    push_exp(2, 16'h0, 1'b0, RSP_LAT, b0 + 2);
    push_exp(3, 16'h0, 1'b0, RSP_LAT, b0 + 3);
    push_exp(0, 16'h0, 1'b0, RSP_LAT, b0 + 4);
    @(posedge clk); #1;
    reset = 1'b1;
    r0 = rsp_cnt;
    for (int t = 0; t < 500 && rsp_cnt < r0 + 5; t++) begin
      @(posedge clk); #1;
    end
    req_valid = '0;
    chk("rr_rsp_count", 32'(rsp_cnt - r0), 32'(5));
    for (int i = 0; i < 5; i++) compare_rsp();
    if (rdy_idx_q.size() >= b0 + 5) begin
      for (int i = 0; i < 5; i++) chk("rr_order", 32'(rdy_idx_q[b0 + i]), 32'(i % NREQ));
      for (int i = 1; i < 5; i++)
        chk("rr_spacing", 32'(rdy_cyc_q[b0 + i] - rdy_cyc_q[b0 + i - 1]), 32'(FRAME_CYCLES + GAP_CYCLES + 3));
    end else begin
      chk("rr_grants", 32'(rdy_idx_q.size() - b0), 32'(5));
    end
    repeat (4) @(posedge clk);
    #1;

    // Single write; a stray strobe during a write must not leak into rsp_data.
    run_frame(0, 32'h5AB87652, NONE, 16'h0, NONE, 16'h0, 16'h0, 1'b0, RSP_LAT, 1'b1);
    run_frame(0, 32'h5AB87652, 30, 16'hDEAD, NONE, 16'h0, 16'h0, 1'b0, RSP_LAT, 1'b1);

    // Reads: strobe mid-WAIT, no strobe, two strobes, strobe on last WAIT cycle, strobes outside WAIT.
    run_frame(1, 32'h6AB8AAAA, 60, 16'hA5A5, NONE, 16'h0, 16'hA5A5, 1'b0, RSP_LAT, 1'b1);
    run_frame(1, 32'h6AB8AAAA, NONE, 16'h0, NONE, 16'h0, 16'h0, 1'b1, RSP_LAT, 1'b1);
    run_frame(2, 32'h6AB8AAAA, 10, 16'h1111, 30, 16'h2222, 16'h1111, 1'b0, RSP_LAT, 1'b1);
    run_frame(3, 32'h6AB8AAAA, FRAME_CYCLES - 1, 16'hBEEF, NONE, 16'h0, 16'hBEEF, 1'b0, RSP_LAT, 1'b1);
    run_frame(3, 32'h6AB8AAAA, -1, 16'h7777, FRAME_CYCLES, 16'h8888, 16'h0, 1'b1, RSP_LAT, 1'b1);

    // Illegal ST/OP frame.
`ifdef MDIO_ARB_OPCHECK_EN
    run_frame(2, 32'h3AB80000, NONE, 16'h0, NONE, 16'h0, 16'h0, 1'b1, 1, 1'b0);
`else
    run_frame(2, 32'h3AB80000, NONE, 16'h0, NONE, 16'h0, 16'h0, 1'b0, RSP_LAT, 1'b1);
`endif

    // Reset at WAIT cycle 20 aborts the frame; the still-valid requester is regranted.
    req_frame[31:0] = 32'h5AB87652;
    req_valid[0] = 1'b1;
    r0 = rsp_cnt;
    seen = 1'b0;
    for (int t = 0; t < 300 && !seen; t++) begin
      @(negedge clk);
      if (req_ready[0]) seen = 1'b1;
    end
    chk("abort_grant", 32'(seen), 32'(1));
    @(posedge clk); #1;
    repeat (21) @(posedge clk);
    #1;
    @(negedge clk);
    chk("abort_t_data_wait", t_data, 32'h5AB87652);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_t_data", t_data, 32'(0));
    chk("abort_mdio_start", 32'(mdio_start), 32'(0));
    chk("abort_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("abort_req_ready", 32'(req_ready), 32'(0));
    chk("abort_rsp_err", 32'(rsp_err), 32'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    chk("abort_no_rsp", 32'(rsp_cnt - r0), 32'(0));
    run_frame(0, 32'h5AB87652, NONE, 16'h0, NONE, 16'h0, 16'h0, 1'b0, RSP_LAT, 1'b1);

    repeat (10) @(posedge clk);
    #1;
    chk("stray_rsp", 32'(obs_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
